// File: rtl/multiport_sync_mem_pkg.sv
// Shared types and constants for the multiport synchronous memory.
// Holds the clear FSM state encoding and the read-during-write mode values.
package multiport_sync_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/multiport_sync_mem_if.sv
// Port bundle for multiport_sync_mem: per-port strobes, addresses and data packed by port index.
// The master side drives requests; the slave side is the memory.
interface multiport_sync_mem_if #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8,
    parameter int PORTS  = 2
);
    logic                      clear_req;
    logic [PORTS-1:0]          writeEnable;
    logic [PORTS-1:0]          readEnable;
    logic [PORTS*ADDR_W-1:0]   address;
    logic [PORTS*WIDTH-1:0]    writeData;
    logic [PORTS*WIDTH-1:0]    readData;
    logic [PORTS-1:0]          readValid;
    logic                      ready;
    logic                      collision;

    modport master (
        output clear_req, writeEnable, readEnable, address, writeData,
        input  readData, readValid, ready, collision
    );

    modport slave (
        input  clear_req, writeEnable, readEnable, address, writeData,
        output readData, readValid, ready, collision
    );
endinterface

// File: rtl/mem_clear_ctrl.sv
// Clear sequencer: walks every address writing zero, then hands the array to the ports.
// Outputs are registered so ready/clr_we/clr_addr change together on the clock edge.
module mem_clear_ctrl
    import multiport_sync_mem_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_req_i,
    output logic              ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_e            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              ready_q;
    logic              clr_we_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
            clr_we_q   <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    // Leave CLEAR only once the final address has been zeroed.
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q    <= RUN;
                        clr_addr_q <= '0;
                        ready_q    <= 1'b1;
                        clr_we_q   <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                RUN: begin
                    if (clear_req_i) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                        ready_q    <= 1'b0;
                        clr_we_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign clr_we_o   = clr_we_q;
    assign clr_addr_o = clr_addr_q;

endmodule

// File: rtl/multiport_sync_mem.sv
// Multi-port synchronous memory with lowest-port-wins write priority, collision flag,
// selectable read-during-write behaviour and a self-clearing array.
module multiport_sync_mem
    import multiport_sync_mem_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int WIDTH    = 8,
    parameter int PORTS    = 2,
    parameter int RDW_MODE = RDW_OLD
) (
    input  logic                clock,
    input  logic                reset,
    multiport_sync_mem_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0]             mem_q [DEPTH];
    logic                         ready;
    logic                         clr_we;
    logic [ADDR_W-1:0]            clr_addr;
    logic                         port_active;

    logic [PORTS-1:0][ADDR_W-1:0] addr;
    logic [PORTS-1:0][WIDTH-1:0]  wdata;
    logic [PORTS-1:0]             win_d;
    logic                         collision_d;
    logic [PORTS-1:0]             fwd_hit_d;
    logic [PORTS-1:0][WIDTH-1:0]  fwd_data_d;

    logic [PORTS-1:0][WIDTH-1:0]  rdata_q;
    logic [PORTS-1:0]             rvalid_q;
    logic                         collision_q;

    mem_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk_i       (clock),
        .rst_ni      (reset),
        .clear_req_i (bus.clear_req),
        .ready_o     (ready),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr)
    );

    assign port_active = ready & reset;

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
        assign addr[gi]                        = bus.address[gi*ADDR_W +: ADDR_W];
        assign wdata[gi]                       = bus.writeData[gi*WIDTH +: WIDTH];
        assign bus.readData[gi*WIDTH +: WIDTH] = rdata_q[gi];
    end

    // A write loses if any lower-index port writes the same address this cycle.
    always_comb begin
        win_d       = '0;
        collision_d = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            win_d[p] = bus.writeEnable[p];
            for (int q = 0; q < p; q++) begin
                if (bus.writeEnable[q] && (addr[q] == addr[p])) begin
                    win_d[p] = 1'b0;
                end
            end
            if (bus.writeEnable[p] && !win_d[p]) begin
                collision_d = 1'b1;
            end
        end
    end

    // Winning write data per read port, used only in new-data read-during-write mode.
    always_comb begin
        fwd_hit_d  = '0;
        fwd_data_d = '0;
        for (int p = 0; p < PORTS; p++) begin
            for (int q = 0; q < PORTS; q++) begin
                if (win_d[q] && (addr[q] == addr[p])) begin
                    fwd_hit_d[p]  = 1'b1;
                    fwd_data_d[p] = wdata[q];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if (clr_we) begin
                mem_q[clr_addr] <= '0;
            end else if (ready) begin
                for (int p = 0; p < PORTS; p++) begin
                    if (win_d[p]) begin
                        mem_q[addr[p]] <= wdata[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata_q     <= '0;
            rvalid_q    <= '0;
            collision_q <= 1'b0;
        end else begin
            collision_q <= port_active & collision_d;
            for (int p = 0; p < PORTS; p++) begin
                rvalid_q[p] <= port_active & bus.readEnable[p];
                if (port_active && bus.readEnable[p]) begin
                    if ((RDW_MODE == RDW_NEW) && fwd_hit_d[p]) begin
                        rdata_q[p] <= fwd_data_d[p];
                    end else begin
                        rdata_q[p] <= mem_q[addr[p]];
                    end
                end
            end
        end
    end

    assign bus.readValid = rvalid_q;
    assign bus.ready     = ready;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_multiport_sync_mem.sv
// Directed testbench for multiport_sync_mem: two-port old/new RDW instances and a four-port instance.
module tb_multiport_sync_mem;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    multiport_sync_mem_if #(.ADDR_W(4), .WIDTH(8), .PORTS(2)) if0 ();
    multiport_sync_mem_if #(.ADDR_W(4), .WIDTH(8), .PORTS(2)) if1 ();
    multiport_sync_mem_if #(.ADDR_W(3), .WIDTH(8), .PORTS(4)) if4 ();

    multiport_sync_mem #(.ADDR_W(4), .WIDTH(8), .PORTS(2), .RDW_MODE(0)) dut_old (
        .clock (clk), .reset (rst_n), .bus (if0.slave)
    );
    multiport_sync_mem #(.ADDR_W(4), .WIDTH(8), .PORTS(2), .RDW_MODE(1)) dut_new (
        .clock (clk), .reset (rst_n), .bus (if1.slave)
    );
    multiport_sync_mem #(.ADDR_W(3), .WIDTH(8), .PORTS(4), .RDW_MODE(0)) dut_four (
        .clock (clk), .reset (rst_n), .bus (if4.slave)
    );

    // The new-data instance sees exactly the same stimulus as the old-data one.
    assign if1.clear_req   = if0.clear_req;
    assign if1.writeEnable = if0.writeEnable;
    assign if1.readEnable  = if0.readEnable;
    assign if1.address     = if0.address;
    assign if1.writeData   = if0.writeData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic [1:0] we, input logic [1:0] re,
                          input logic [3:0] a0, input logic [3:0] a1,
                          input logic [7:0] d0, input logic [7:0] d1);
        if0.writeEnable = we;
        if0.readEnable  = re;
        if0.address     = {a1, a0};
        if0.writeData   = {d1, d0};
    endtask

    task automatic drive4(input logic [3:0] we, input logic [3:0] re,
                          input logic [2:0] a0, input logic [2:0] a1,
                          input logic [2:0] a2, input logic [2:0] a3,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
        if4.writeEnable = we;
        if4.readEnable  = re;
        if4.address     = {a3, a2, a1, a0};
        if4.writeData   = {d3, d2, d1, d0};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({if0.ready, if0.readValid, if0.collision, if0.readData} !== 20'h0) begin
            $display("FAIL reset_state: ready/valid/coll/data=%h expected 0", {if0.ready, if0.readValid, if0.collision, if0.readData});
        end else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            total_cnt++;
            if (if0.ready !== (i == 15)) begin
                $display("FAIL init_ready cycle %0d: got %b expected %b", i, if0.ready, (i == 15));
            end else pass_cnt++;
            total_cnt++;
            if (if4.ready !== (i >= 7)) begin
                $display("FAIL init_ready4 cycle %0d: got %b expected %b", i, if4.ready, (i >= 7));
            end else pass_cnt++;
        end
        for (int a = 0; a < 16; a += 2) begin
            drive2(2'b00, 2'b11, 4'(a), 4'(a + 1), 8'h00, 8'h00);
            tick();
            total_cnt++;
            if (if0.readData !== 16'h0000 || if0.readValid !== 2'b11) begin
                $display("FAIL init_zero @%0d: data=%h valid=%b expected 0000/11", a, if0.readData, if0.readValid);
            end else pass_cnt++;
        end
        drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        tick();
    endtask

    task automatic test_write_read();
        drive2(2'b01, 2'b00, 4'd3, 4'd0, 8'hA5, 8'h00);
        tick();
        drive2(2'b00, 2'b10, 4'd0, 4'd3, 8'h00, 8'h00);
        tick();
        total_cnt++;
        if (if0.readData[15:8] !== 8'hA5 || if0.readValid !== 2'b10) begin
            $display("FAIL write_read: data1=%h valid=%b expected a5/10", if0.readData[15:8], if0.readValid);
        end else pass_cnt++;
        drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        tick();
        total_cnt++;
        if (if0.readData[15:8] !== 8'hA5 || if0.readValid !== 2'b00) begin
            $display("FAIL read_hold: data1=%h valid=%b expected a5/00", if0.readData[15:8], if0.readValid);
        end else pass_cnt++;
    endtask

    task automatic test_collision();
        drive2(2'b11, 2'b00, 4'd7, 4'd7, 8'h11, 8'h22);
        tick();
        total_cnt++;
        if (if0.collision !== 1'b1) begin
            $display("FAIL collision_pulse: got %b expected 1", if0.collision);
        end else pass_cnt++;
        drive2(2'b00, 2'b01, 4'd7, 4'd0, 8'h00, 8'h00);
        tick();
        total_cnt++;
        if (if0.collision !== 1'b0) begin
            $display("FAIL collision_once: got %b expected 0", if0.collision);
        end else pass_cnt++;
        total_cnt++;
        if (if0.readData[7:0] !== 8'h11) begin
            $display("FAIL collision_winner: got %h expected 11", if0.readData[7:0]);
        end else pass_cnt++;
        // Distinct addresses both commit, no collision.
        drive2(2'b11, 2'b00, 4'd1, 4'd2, 8'h12, 8'h34);
        tick();
        total_cnt++;
        if (if0.collision !== 1'b0) begin
            $display("FAIL distinct_no_coll: got %b expected 0", if0.collision);
        end else pass_cnt++;
        drive2(2'b00, 2'b11, 4'd1, 4'd2, 8'h00, 8'h00);
        tick();
        total_cnt++;
        if (if0.readData !== 16'h3412) begin
            $display("FAIL distinct_commit: got %h expected 3412", if0.readData);
        end else pass_cnt++;
        drive2(2'b00, 2'b11, 4'd2, 4'd2, 8'h00, 8'h00);
        tick();
        total_cnt++;
        if (if0.readData !== 16'h3434) begin
            $display("FAIL same_addr_read: got %h expected 3434", if0.readData);
        end else pass_cnt++;
        drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        tick();
    endtask

    task automatic test_rdw();
        drive2(2'b01, 2'b00, 4'd5, 4'd0, 8'h33, 8'h00);
        tick();
        drive2(2'b01, 2'b10, 4'd5, 4'd5, 8'h44, 8'h00);
        tick();
        total_cnt++;
        if (if0.readData[15:8] !== 8'h33) begin
            $display("FAIL rdw_old: got %h expected 33", if0.readData[15:8]);
        end else pass_cnt++;
        total_cnt++;
        if (if1.readData[15:8] !== 8'h44) begin
            $display("FAIL rdw_new: got %h expected 44", if1.readData[15:8]);
        end else pass_cnt++;
        drive2(2'b01, 2'b01, 4'd5, 4'd0, 8'h55, 8'h00);
        tick();
        total_cnt++;
        if (if0.readData[7:0] !== 8'h44 || if1.readData[7:0] !== 8'h55) begin
            $display("FAIL rdw_own_port: old=%h new=%h expected 44/55", if0.readData[7:0], if1.readData[7:0]);
        end else pass_cnt++;
        drive2(2'b00, 2'b11, 4'd5, 4'd5, 8'h00, 8'h00);
        tick();
        total_cnt++;
        if (if0.readData !== 16'h5555 || if1.readData !== 16'h5555) begin
            $display("FAIL rdw_after: old=%h new=%h expected 5555", if0.readData, if1.readData);
        end else pass_cnt++;
        drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        tick();
    endtask

    task automatic test_four_ports();
        drive4(4'b1111, 4'b0000, 3'd6, 3'd1, 3'd4, 3'd3, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        tick();
        total_cnt++;
        if (if4.collision !== 1'b0) begin
            $display("FAIL four_no_coll: got %b expected 0", if4.collision);
        end else pass_cnt++;
        drive4(4'b0000, 4'b1111, 3'd3, 3'd6, 3'd1, 3'd4, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        total_cnt++;
        if (if4.readData !== 32'hC3B2A1D4 || if4.readValid !== 4'b1111) begin
            $display("FAIL four_read: data=%h valid=%b expected c3b2a1d4/1111", if4.readData, if4.readValid);
        end else pass_cnt++;
        drive4(4'b1111, 4'b0000, 3'd0, 3'd5, 3'd5, 3'd5, 8'h50, 8'h51, 8'h52, 8'h53);
        tick();
        total_cnt++;
        if (if4.collision !== 1'b1) begin
            $display("FAIL four_coll: got %b expected 1", if4.collision);
        end else pass_cnt++;
        drive4(4'b0000, 4'b0011, 3'd5, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        total_cnt++;
        if (if4.readData[15:0] !== 16'h5051) begin
            $display("FAIL four_winner: got %h expected 5051", if4.readData[15:0]);
        end else pass_cnt++;
        drive4(4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
    endtask

    task automatic test_clear();
        drive2(2'b11, 2'b00, 4'd15, 4'd0, 8'h5A, 8'h6B);
        tick();
        if0.clear_req = 1'b1;
        drive2(2'b00, 2'b10, 4'd0, 4'd3, 8'h00, 8'h00);
        tick();
        if0.clear_req = 1'b0;
        total_cnt++;
        if (if0.ready !== 1'b0 || if0.readValid !== 2'b10 || if0.readData[15:8] !== 8'hA5) begin
            $display("FAIL clear_req_cycle: ready=%b valid=%b data1=%h expected 0/10/a5", if0.ready, if0.readValid, if0.readData[15:8]);
        end else pass_cnt++;
        // Port requests during CLEAR are ignored.
        drive2(2'b11, 2'b11, 4'd9, 4'd9, 8'hEE, 8'hFF);
        for (int i = 0; i < 7; i++) begin
            tick();
            total_cnt++;
            if (if0.ready !== 1'b0 || if0.readValid !== 2'b00 || if0.collision !== 1'b0) begin
                $display("FAIL clearing %0d: ready=%b valid=%b coll=%b expected 0/00/0", i, if0.ready, if0.readValid, if0.collision);
            end else pass_cnt++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++;
        if (if0.ready !== 1'b0 || if0.readData !== 16'h0000) begin
            $display("FAIL mid_clear_reset: ready=%b data=%h expected 0/0000", if0.ready, if0.readData);
        end else pass_cnt++;
        drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        for (int i = 0; i < 16; i++) begin
            tick();
            total_cnt++;
            if (if0.ready !== (i == 15)) begin
                $display("FAIL reclear_ready cycle %0d: got %b expected %b", i, if0.ready, (i == 15));
            end else pass_cnt++;
        end
        for (int a = 0; a < 16; a += 2) begin
            drive2(2'b00, 2'b11, 4'(a), 4'(a + 1), 8'h00, 8'h00);
            tick();
            total_cnt++;
            if (if0.readData !== 16'h0000 || if0.readValid !== 2'b11) begin
                $display("FAIL cleared_zero @%0d: data=%h valid=%b expected 0000/11", a, if0.readData, if0.readValid);
            end else pass_cnt++;
        end
        drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        tick();
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        if0.clear_req = 1'b0;
        if4.clear_req = 1'b0;
        drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        drive4(4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        test_reset();
        test_write_read();
        test_collision();
        test_rdw();
        test_four_ports();
        test_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
